// File: rtl/sipo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sipo_pkg                                                   |
// | Description : Shared constants and types for the SIPO shift register:    |
// |               default word width, bit-counter width helper and the       |
// |               cnt_t type sized for the default width.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package sipo_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 4;

  // Counter must hold 0..WIDTH-1; sized with WIDTH+1 so that WIDTH itself
  // would also fit, keeping the port width identical to the documented one.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SIPO_CNT_W_DEFAULT = $clog2(SIPO_WIDTH_DEFAULT + 1);

  typedef logic [SIPO_CNT_W_DEFAULT-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sipo_bit_counter                                           |
// | Description : Modulo-WIDTH counter with enable. Counts enabled edges and |
// |               emits a registered one-cycle wrap pulse on the edge that   |
// |               takes the count from WIDTH-1 back to 0.                    |
// | Ports       : clk   - rising-edge clock                                  |
// |               rst_n - asynchronous active-low reset                      |
// |               en    - count enable                                       |
// |               count - current count, 0..WIDTH-1 (registered)             |
// |               wrap  - one-cycle pulse after the wrapping edge            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (count_q == C_LAST_CNT) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sipo_shift_reg                                             |
// | Description : Serial-in/parallel-out shift register. On every clock with |
// |               load high the serial bit enters out[0] and older bits move |
// |               toward the MSB. A frame pulse marks each completed         |
// |               WIDTH-bit word. All outputs are registered.                |
// | Ports       : clk     - rising-edge clock                                |
// |               rst_n   - asynchronous active-low reset                    |
// |               load    - shift enable (1 = capture cnst, 0 = hold)        |
// |               cnst    - serial data input                                |
// |               out     - parallel register contents [WIDTH-1:0]           |
// |               bit_cnt - bits captured in the current word                |
// |               frame   - one-cycle pulse after the WIDTH-th bit           |
// |               parity  - XOR of out (only with SIPO_PARITY_EN defined)    |
// | Options     : SIPO_PARITY_EN - adds the registered parity output port.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        cnst,
  output logic [WIDTH-1:0]            out,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        frame
`ifdef SIPO_PARITY_EN
  ,
  output logic                        parity
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // New bit enters at the LSB; out[WIDTH-1] is the oldest bit and is dropped.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = {out_q[WIDTH-2:0], cnst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load),
    .count (bit_cnt),
    .wrap  (frame)
  );

`ifdef SIPO_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Computed from the next register value so parity tracks out in the same
  // cycle rather than lagging it by one shift.
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = ^out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_shift_reg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sipo_shift_reg                                          |
// | Description : Self-checking bench for sipo_shift_reg (WIDTH=4). A        |
// |               bit-history model predicts out/bit_cnt/frame; directed     |
// |               sequences pin literal values, then randomized load/cnst    |
// |               with occasional asynchronous resets.                       |
// | Options     : SIPO_PARITY_EN - also checks the parity port.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sipo_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic             cnst;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    bit_cnt;
  logic             frame;
`ifdef SIPO_PARITY_EN
  logic             parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every bit captured since the last reset (most recent at the back,
  // only the last WIDTH kept), how many were captured, and the frame flag.
  bit hist[$];
  int total   = 0;
  bit m_frame = 1'b0;
  bit chk_en  = 1'b0;

  sipo_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .cnst    (cnst),
    .out     (out),
    .bit_cnt (bit_cnt),
    .frame   (frame)
`ifdef SIPO_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  always #10 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_out();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < hist.size(); i++) v[i] = hist[hist.size()-1-i];
    return v;
  endfunction

  function automatic int model_cnt();
    return total % WIDTH;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    hist.delete();
    total   = 0;
    m_frame = 1'b0;
  endtask

  // Drive one cycle, let the edge happen, then advance the model.
  task automatic clock(input logic ld, input logic c);
    load = ld;
    cnst = c;
    @(posedge clk);
    #1;
    if (rst_n === 1'b1) begin
      if (ld === 1'b1) begin
        hist.push_back(c);
        if (hist.size() > WIDTH) void'(hist.pop_front());
        total++;
        m_frame = ((total % WIDTH) == 0);
      end else begin
        m_frame = 1'b0;
      end
    end
  endtask

  // Literal expectation checked against both DUT and model.
  task automatic lit(input string name, input logic [WIDTH-1:0] e_out,
                     input int e_cnt, input logic e_frame);
    check({name, " out"},       out,         e_out);
    check({name, " model_out"}, model_out(), e_out);
    check({name, " bit_cnt"},   bit_cnt,     e_cnt);
    check({name, " frame"},     frame,       e_frame);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc out",     out,     model_out());
        check("cyc bit_cnt", bit_cnt, model_cnt());
        check("cyc frame",   frame,   m_frame);
`ifdef SIPO_PARITY_EN
        check("cyc parity",  parity,  ^model_out());
`endif
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] seq_up [4];
    logic [WIDTH-1:0] seq_dn [4];
    seq_up = '{4'h1, 4'h3, 4'h7, 4'hF};
    seq_dn = '{4'hE, 4'hC, 4'h8, 4'h0};

    rst_n = 1'b0;
    load  = 1'b0;
    cnst  = 1'b0;
    reset_model();
    chk_en = 1'b1;

    // Reset held while load/cnst toggle: nothing may change.
    for (int i = 0; i < 6; i++) begin
      clock(1'b1, 1'(i % 2));
      lit("t1 reset", 4'h0, 0, 1'b0);
    end
    rst_n = 1'b1;

    // load low: register holds zero regardless of cnst.
    for (int i = 0; i < 5; i++) begin
      clock(1'b0, 1'b1);
      lit("t2 hold", 4'h0, 0, 1'b0);
    end

    // Five zero bits: frame after the 4th edge only.
    for (int i = 0; i < 5; i++) begin
      clock(1'b1, 1'b0);
      lit("t3 zeros", 4'h0, (i + 1) % WIDTH, (i == 3));
    end

    // Realign the word boundary.
    #2 rst_n = 1'b0;
    reset_model();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      clock(1'b1, 1'b1);
      lit("t4 ones", seq_up[i], (i + 1) % WIDTH, (i == 3));
    end

    for (int i = 0; i < 4; i++) begin
      clock(1'b1, 1'b0);
      lit("t5 drain", seq_dn[i], (i + 1) % WIDTH, (i == 3));
    end

    // Gap in load mid-word.
    clock(1'b1, 1'b1);
    lit("t6 b0", 4'h1, 1, 1'b0);
    clock(1'b1, 1'b1);
    lit("t6 b1", 4'h3, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clock(1'b0, 1'($urandom_range(0, 1)));
      lit("t6 gap", 4'h3, 2, 1'b0);
    end
    clock(1'b1, 1'b1);
    lit("t6 b2", 4'h7, 3, 1'b0);
    clock(1'b1, 1'b1);
    lit("t6 b3", 4'hF, 0, 1'b1);

    // Unknown serial input while not loading must not disturb state.
    clock(1'b0, 1'bx);
    lit("tx hold", 4'hF, 0, 1'b0);

    // Asynchronous reset between edges, mid-word.
    clock(1'b1, 1'b0);
    lit("t7 pre", 4'hE, 1, 1'b0);
    #4 rst_n = 1'b0;
    reset_model();
    #1;
    lit("t7 async", 4'h0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clock(1'b1, 1'b1);
    lit("t7 after", 4'h1, 1, 1'b0);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      clock(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) begin
        #3 rst_n = 1'b0;
        reset_model();
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
